im_serial_loader: RTL and testbench
===================================

Name: im_serial_loader

Overview:
- Hardware program loader for the single-cycle computer's instruction memory; replaces the simulation-only memory file preload.
- Accepts a framed byte stream over a valid/ready interface and assembles MSB-first 32-bit words.
- Writes each word to consecutive instruction-memory word addresses through a one-cycle write strobe.
- Holds the CPU in reset while loading, then releases it, or keeps it held if the load fails.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse that begins a load session.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_WIDTH  word address for the write.
- im_wdata  out  32  word to write.
- cpu_rstn  out  1  active-low reset to the CPU core.
- busy  out  1  session in progress.
- done  out  1  last session succeeded (sticky).
- err  out  1  last session failed (sticky).

Behaviour:
- Reset values (asynchronous): state IDLE, rx_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rstn=1, busy=0, done=0, err=0. The CPU runs whatever image is already in memory.
- Byte transfer: a byte is accepted on a rising edge when rx_valid && rx_ready. rx_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N*4 payload bytes, each word MSB first.
  - One checksum byte.
- Checksum: XOR of every byte from LEN_HI through the last payload byte.
- IDLE, DONE, ERR:
  - load_start=1 goes to LEN_HI.
  - Same edge: cpu_rstn<=0, busy<=1, done<=0, err<=0, im_addr<=0, running XOR<=0, byte counter<=0.
- LEN_HI → LEN_LO → DATA on accepted bytes.
- At the LEN_LO accept:
  - N==0 goes to CHECK.
  - N > 2^ADDR_WIDTH goes to ERR.
- DATA:
  - Each accepted byte shifts into im_wdata (im_wdata <= {im_wdata[23:0], rx_data}) and increments a 2-bit byte counter.
  - The 4th byte's accept goes to WRITE.
- WRITE, exactly one cycle:
  - im_we=1 with im_addr and im_wdata stable; rx_ready=0.
  - On exit, im_addr increments and the words-written counter increments.
  - Goes to CHECK if words written == N, else DATA.
- Write latency: the word is written at the rising edge after the edge that accepted its 4th byte.
- CHECK, on accept:
  - Byte == running XOR: go to DONE with done<=1, busy<=0, cpu_rstn<=1.
  - Otherwise: go to ERR with err<=1, busy<=0, cpu_rstn stays 0.
- Partial loads: words already written in a failed session remain in memory. The CPU stays in reset until a later session succeeds.
- load_start while busy is ignored.
- rx_valid in IDLE/DONE/ERR is not accepted (rx_ready=0); those bytes are dropped by the source.
- im_addr after success equals N mod 2^ADDR_WIDTH. At N == 2^ADDR_WIDTH it wraps to 0 after the last write; no error.
- Stall: rx_valid may deassert for any number of cycles in any accepting state; the state is held, with no timeout.
- rstn asserted mid-session: immediate return to reset values, including cpu_rstn=1. Memory contents are undefined for that session.

Test Plan:
- Reset release, then load_start with bytes 00 01 20 08 00 05 2C:
  - exactly one im_we pulse with addr 0, data 0x20080005;
  - then done=1, err=0, cpu_rstn=1, im_addr=1.
- N=3 with rx_valid toggling every other cycle and correct checksum:
  - three im_we pulses at addr 0,1,2 with the correct words;
  - rx_ready=0 during each WRITE cycle;
  - done=1.
- Same 1-word frame with checksum 2D:
  - the word is written at addr 0;
  - then err=1, done=0, cpu_rstn stays 0;
  - a following correct session clears err and sets done.
- Length bytes 01 01 (257, ADDR_WIDTH=8):
  - err=1 right after LEN_LO;
  - no im_we pulses; cpu_rstn=0.
- Frame 00 00 00 (N=0): no writes; done=1, cpu_rstn=1. A second load_start pulse during the header is ignored.
- rstn driven low mid-payload: all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/im_serial_loader.sv
// Instruction-memory program loader: receives a framed byte stream (length, payload, XOR checksum),
// writes MSB-first 32-bit words to consecutive addresses and gates the CPU reset on the result.
module im_serial_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] im_addr_r;
    logic [31:0]           im_wdata_r;
    logic                  cpu_rstn_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic [7:0]            csum_r;
    logic [7:0]            len_hi_r;
    logic [15:0]           len_r;
    logic [1:0]            bcnt_r;
    logic [CNT_W-1:0]      wcnt_r;
    logic                  rx_ready_s;
    logic                  im_we_s;
    logic                  accept_s;
    logic [15:0]           n_s;
    logic                  len_zero_s;
    logic                  len_over_s;
    logic                  last_word_s;
    logic                  csum_ok_s;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign accept_s    = rx_valid && rx_ready_s;
    assign n_s         = {len_hi_r, rx_data};
    assign len_zero_s  = (n_s == 16'd0);
    // A full memory (N == 2^ADDR_WIDTH) is legal; only strictly larger images are rejected.
    assign len_over_s  = (32'(n_s) > (32'd1 << ADDR_WIDTH));
    assign last_word_s = ((32'(wcnt_r) + 32'd1) == 32'(len_r));
    assign csum_ok_s   = (rx_data == csum_r);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) state_nxt_s = ST_LEN_HI;
                else            state_nxt_s = state_r;
            end
            ST_LEN_HI: begin
                if (accept_s) state_nxt_s = ST_LEN_LO;
                else          state_nxt_s = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (!accept_s)      state_nxt_s = ST_LEN_LO;
                else if (len_zero_s) state_nxt_s = ST_CHECK;
                else if (len_over_s) state_nxt_s = ST_ERR;
                else                 state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && (bcnt_r == 2'd3)) state_nxt_s = ST_WRITE;
                else                              state_nxt_s = ST_DATA;
            end
            ST_WRITE: begin
                if (last_word_s) state_nxt_s = ST_CHECK;
                else             state_nxt_s = ST_DATA;
            end
            ST_CHECK: begin
                if (!accept_s)     state_nxt_s = ST_CHECK;
                else if (csum_ok_s) state_nxt_s = ST_DONE;
                else                state_nxt_s = ST_ERR;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        rx_ready_s = 1'b0;
        im_we_s    = 1'b0;
        case (state_r)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: rx_ready_s = 1'b1;
            ST_WRITE:                                im_we_s    = 1'b1;
            default: begin
                rx_ready_s = 1'b0;
                im_we_s    = 1'b0;
            end
        endcase
    end

    // Session datapath: header capture, word assembly, address/count and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            im_addr_r  <= '0;
            im_wdata_r <= 32'd0;
            cpu_rstn_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            csum_r     <= 8'd0;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            bcnt_r     <= 2'd0;
            wcnt_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (load_start) begin
                        cpu_rstn_r <= 1'b0;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        im_addr_r  <= '0;
                        csum_r     <= 8'd0;
                        bcnt_r     <= 2'd0;
                        wcnt_r     <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= rx_data;
                        csum_r   <= csum_update(csum_r, rx_data);
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_r  <= n_s;
                        csum_r <= csum_update(csum_r, rx_data);
                        if (!len_zero_s && len_over_s) begin
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        im_wdata_r <= {im_wdata_r[23:0], rx_data};
                        bcnt_r     <= bcnt_r + 2'd1;
                        csum_r     <= csum_update(csum_r, rx_data);
                    end
                end
                ST_WRITE: begin
                    im_addr_r <= im_addr_r + ADDR_WIDTH'(1);
                    wcnt_r    <= wcnt_r + CNT_W'(1);
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        busy_r <= 1'b0;
                        if (csum_ok_s) begin
                            done_r     <= 1'b1;
                            cpu_rstn_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready = rx_ready_s;
    assign im_we    = im_we_s;
    assign im_addr  = im_addr_r;
    assign im_wdata = im_wdata_r;
    assign cpu_rstn = cpu_rstn_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_im_serial_loader.sv
// Directed self-checking bench for im_serial_loader: framed loads, stalls, checksum and length errors,
// ignored restarts and asynchronous reset mid-session.
module tb_im_serial_loader;

    logic        clk;
    logic        rstn;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rstn;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    // Write monitor (recorded here, compared in the tests)
    int          wr_cnt = 0;
    int          ready_viol = 0;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    im_serial_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = im_addr;
                wr_data[wr_cnt] = im_wdata;
            end
            if (rx_ready) ready_viol = ready_viol + 1;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Presents one byte from a falling edge and holds it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            tests++; fails++;
            $display("FAIL send_timeout: rx_ready stayed 0 for byte %h, required 1", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        tests++; if (im_we !== 1'b0)    begin fails++; $display("FAIL reset_im_we: got %b want 0", im_we); end
        tests++; if (im_addr !== 8'h00) begin fails++; $display("FAIL reset_im_addr: got %h want 00", im_addr); end
        tests++; if (im_wdata !== 32'h0) begin fails++; $display("FAIL reset_im_wdata: got %h want 0", im_wdata); end
        tests++; if (cpu_rstn !== 1'b1) begin fails++; $display("FAIL reset_cpu_rstn: got %b want 1", cpu_rstn); end
        tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int base;
        base = wr_cnt;
        pulse_start();
        tests++; if ({busy, cpu_rstn} !== 2'b10) begin fails++; $display("FAIL single_session_flags: busy,cpu_rstn got %b want 10", {busy, cpu_rstn}); end
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h2C, 0);
        tests++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL single_wr_count: got %0d want 1", wr_cnt - base); end
        tests++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h20080005) begin
            fails++; $display("FAIL single_word: got %h@%h want 20080005@00", wr_data[base], wr_addr[base]); end
        tests++; if ({done, err, cpu_rstn, busy} !== 4'b1010) begin fails++; $display("FAIL single_status: done,err,cpu_rstn,busy got %b want 1010", {done, err, cpu_rstn, busy}); end
        tests++; if (im_addr !== 8'h01) begin fails++; $display("FAIL single_im_addr: got %h want 01", im_addr); end
    endtask

    task automatic test_stall_three_words();
        int base;
        int viol0;
        logic [31:0] words [0:2];
        words[0] = 32'h11223344; words[1] = 32'hA5A5A5A5; words[2] = 32'hDEADBEEF;
        base = wr_cnt; viol0 = ready_viol;
        pulse_start();
        send_byte(8'h00, 1); send_byte(8'h03, 1);
        for (int w = 0; w < 3; w++)
            for (int k = 3; k >= 0; k--) send_byte(words[w][k*8 +: 8], 1);
        send_byte(8'h65, 1);
        tests++; if (wr_cnt - base !== 3) begin fails++; $display("FAIL stall_wr_count: got %0d want 3", wr_cnt - base); end
        for (int w = 0; w < 3; w++) begin
            tests++;
            if (wr_addr[base+w] !== 8'(w) || wr_data[base+w] !== words[w]) begin
                fails++; $display("FAIL stall_word%0d: got %h@%h want %h@%h", w, wr_data[base+w], wr_addr[base+w], words[w], 8'(w));
            end
        end
        tests++; if (ready_viol !== viol0) begin fails++; $display("FAIL write_rx_ready: %0d WRITE cycles had rx_ready=1, want 0", ready_viol - viol0); end
        tests++; if ({done, err, cpu_rstn} !== 3'b101) begin fails++; $display("FAIL stall_status: done,err,cpu_rstn got %b want 101", {done, err, cpu_rstn}); end
        tests++; if (im_addr !== 8'h03) begin fails++; $display("FAIL stall_im_addr: got %h want 03", im_addr); end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h2D, 0);
        tests++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h20080005) begin
            fails++; $display("FAIL badcs_write: got %0d writes, %h@%h want 1, 20080005@00", wr_cnt - base, wr_data[base], wr_addr[base]); end
        tests++; if ({err, done, cpu_rstn, busy} !== 4'b1000) begin fails++; $display("FAIL badcs_status: err,done,cpu_rstn,busy got %b want 1000", {err, done, cpu_rstn, busy}); end
        repeat (3) @(negedge clk);
        tests++; if (cpu_rstn !== 1'b0) begin fails++; $display("FAIL badcs_cpu_held: got %b want 0", cpu_rstn); end
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h2C, 0);
        tests++; if ({err, done, cpu_rstn} !== 3'b011) begin fails++; $display("FAIL recover_status: err,done,cpu_rstn got %b want 011", {err, done, cpu_rstn}); end
    endtask

    task automatic test_len_overflow();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        tests++; if ({err, done, busy, cpu_rstn} !== 4'b1000) begin fails++; $display("FAIL overflow_status: err,done,busy,cpu_rstn got %b want 1000", {err, done, busy, cpu_rstn}); end
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL overflow_rx_ready: got %b want 0", rx_ready); end
        repeat (4) @(negedge clk);
        tests++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL overflow_writes: got %0d want 0", wr_cnt - base); end
    endtask

    task automatic test_empty_and_restart();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL empty_writes: got %0d want 0", wr_cnt - base); end
        tests++; if ({done, err, cpu_rstn, busy} !== 4'b1010) begin fails++; $display("FAIL empty_status: done,err,cpu_rstn,busy got %b want 1010", {done, err, cpu_rstn, busy}); end
        tests++; if (im_addr !== 8'h00) begin fails++; $display("FAIL empty_im_addr: got %h want 00", im_addr); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        tests++; if ({busy, cpu_rstn} !== 2'b10) begin fails++; $display("FAIL midload_flags: busy,cpu_rstn got %b want 10", {busy, cpu_rstn}); end
        #2 rstn = 1'b0;
        #1;
        tests++; if ({busy, done, err, cpu_rstn, rx_ready, im_we} !== 6'b000100) begin
            fails++; $display("FAIL async_flags: busy,done,err,cpu_rstn,rx_ready,im_we got %b want 000100", {busy, done, err, cpu_rstn, rx_ready, im_we}); end
        tests++; if (im_addr !== 8'h00 || im_wdata !== 32'h0) begin
            fails++; $display("FAIL async_data: addr %h wdata %h want 00 00000000", im_addr, im_wdata); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tests++; if ({busy, rx_ready} !== 2'b00) begin fails++; $display("FAIL post_reset_idle: busy,rx_ready got %b want 00", {busy, rx_ready}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall_three_words();
        test_bad_checksum();
        test_len_overflow();
        test_empty_and_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
